spi_master_byte: RTL and testbench

SPI controller (initiator) that shifts one byte per request, full-duplex, MSB first, SPI mode 0 (CPOL=0, CPHA=0), toward the PET clone's `spi_byte` target. It generates `spi_sclk` and `spi_cs_n` from `sys_clk` and drives the target's receive line while sampling its transmit line. It sits on the bench/host side of the link and gives board-level test logic a request/done byte interface. `spi_cs_n` can stay asserted across consecutive bytes.

---
 rtl/spi_master_byte.sv | 183 ++++++++++++++++++
 tb/tb_spi_master_byte.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_byte.sv
// rtl/spi_master_byte.sv - SPI mode-0 controller shifting one byte per request, MSB first
module spi_master_byte #(
  parameter int HALF = 4
) (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       last,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_tx,
  input  logic       spi_rx
);

  // Half-period counter just wide enough to reach HALF-1.
  localparam int            CW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] HALF_TC = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READY,
    S_LOW,
    S_HIGH,
    S_CS_HOLD,
    S_CS_GAP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] half_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_shift;     // remaining bits after the MSB already on spi_tx
  logic [7:0]    rx_shift;
  logic          last_flag;

  logic half_done;
  logic accept;
  logic do_rise;
  logic do_fall_next;
  logic do_fall_last;
  logic do_cs_up;
  logic do_gap_end;

  assign half_done = (half_cnt == HALF_TC);

  // State register.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; each strobe marks the edge on which an output changes.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    do_rise      = 1'b0;
    do_fall_next = 1'b0;
    do_fall_last = 1'b0;
    do_cs_up     = 1'b0;
    do_gap_end   = 1'b0;
    case (state)
      S_IDLE, S_READY: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_LOW;
        end
      end
      S_LOW: begin
        if (half_done) begin
          do_rise    = 1'b1;
          state_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (half_done) begin
          if (bit_cnt == 3'd7) begin
            do_fall_last = 1'b1;
            state_next   = last_flag ? S_CS_HOLD : S_READY;
          end else begin
            do_fall_next = 1'b1;
            state_next   = S_LOW;
          end
        end
      end
      S_CS_HOLD: begin
        if (half_done) begin
          do_cs_up   = 1'b1;
          state_next = S_CS_GAP;
        end
      end
      S_CS_GAP: begin
        if (half_done) begin
          do_gap_end = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Half-period timer: restarts at every phase change and rests at zero between bytes.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      half_cnt <= '0;
    end else if (accept || half_done || state == S_IDLE || state == S_READY) begin
      half_cnt <= '0;
    end else begin
      half_cnt <= half_cnt + CW'(1);
    end
  end

  // Shift registers and bit counter: load on accept, sample on rising sclk, advance on falling sclk.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      last_flag <= 1'b0;
    end else begin
      if (accept) begin
        tx_shift  <= tx_byte[6:0];
        last_flag <= last;
        bit_cnt   <= '0;
      end
      if (do_rise) begin
        rx_shift <= {rx_shift[6:0], spi_rx};
      end
      if (do_fall_next) begin
        tx_shift <= {tx_shift[5:0], 1'b0};
        bit_cnt  <= bit_cnt + 3'd1;
      end
    end
  end

  // Registered pin and handshake outputs; spi_tx only moves on accept, falling sclk or CS release.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_byte  <= 8'h00;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_tx   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        spi_cs_n <= 1'b0;
        spi_tx   <= tx_byte[7];
      end
      if (do_rise) begin
        spi_sclk <= 1'b1;
      end
      if (do_fall_next) begin
        spi_sclk <= 1'b0;
        spi_tx   <= tx_shift[6];
      end
      if (do_fall_last) begin
        spi_sclk <= 1'b0;
        rx_byte  <= rx_shift;
        done     <= 1'b1;
        if (!last_flag) begin
          busy <= 1'b0;
        end
      end
      if (do_cs_up) begin
        spi_cs_n <= 1'b1;
        spi_tx   <= 1'b0;
      end
      if (do_gap_end) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// tb/tb_spi_master_byte.sv - self-checking bench for spi_master_byte
module tb_spi_master_byte;

  localparam int H  = 4;
  localparam int HB = 2;

  logic sys_clk = 1'b0;
  logic sys_reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Instance A (HALF=4)
  logic       start_a, last_a, busy_a, done_a, sclk_a, cs_a, tx_a, rx_a;
  logic [7:0] tx_byte_a, rx_byte_a;
  // Instance B (HALF=2)
  logic       start_b, last_b, busy_b, done_b, sclk_b, cs_b, tx_b, rx_b;
  logic [7:0] tx_byte_b, rx_byte_b;

  spi_master_byte #(.HALF(H)) dut_a (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .start(start_a), .tx_byte(tx_byte_a),
    .last(last_a), .busy(busy_a), .done(done_a), .rx_byte(rx_byte_a), .spi_sclk(sclk_a),
    .spi_cs_n(cs_a), .spi_tx(tx_a), .spi_rx(rx_a)
  );

  spi_master_byte #(.HALF(HB)) dut_b (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .start(start_b), .tx_byte(tx_byte_b),
    .last(last_b), .busy(busy_b), .done(done_b), .rx_byte(rx_byte_b), .spi_sclk(sclk_b),
    .spi_cs_n(cs_b), .spi_tx(tx_b), .spi_rx(rx_b)
  );

  // Behavioural mode-0 target for A: returns ta_pre MSB first, advancing on falling sclk.
  logic [7:0] ta_pre = 8'h5B;
  int         ta_idx = 0;
  logic       loop_a = 1'b0;
  always @(negedge sclk_a or posedge cs_a) begin
    if (cs_a) ta_idx <= 0;
    else      ta_idx <= ta_idx + 1;
  end
  assign rx_a = loop_a ? tx_a : ((!cs_a && ta_idx < 8) ? ta_pre[7 - ta_idx] : 1'b0);

  // Behavioural spi_byte-like target for B: preloaded 8'h3C, receives a byte, counts valid pulses.
  logic [7:0] tb_pre = 8'h3C;
  int         tb_idx = 0;
  int         tb_bits = 0;
  int         tb_valid = 0;
  logic [7:0] tb_rcv = 8'h00;
  always @(negedge sclk_b or posedge cs_b) begin
    if (cs_b) tb_idx <= 0;
    else      tb_idx <= tb_idx + 1;
  end
  always @(posedge sclk_b or posedge cs_b) begin
    if (cs_b) begin
      tb_bits <= 0;
    end else begin
      tb_rcv <= {tb_rcv[6:0], tx_b};
      if (tb_bits == 7) begin
        tb_bits  <= 0;
        tb_valid <= tb_valid + 1;
      end else begin
        tb_bits <= tb_bits + 1;
      end
    end
  end
  assign rx_b = (!cs_b && tb_idx < 8) ? tb_pre[7 - tb_idx] : 1'b0;

  // Scoreboard counters and transaction-level model of instance A
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  bit         m_active = 1'b0;
  bit         m_last = 1'b0;
  int         m_e0 = 0;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_rx_prev = 8'h00;
  logic [7:0] m_rx_new = 8'h00;

  // Event recorders for A
  int         rise_cnt = 0, done_cnt = 0, cs_rise_cnt = 0;
  int         t_done = -1, t_cs = -1, t_busy = -1;
  logic [7:0] tx_seen = 8'h00;
  logic       p_sclk = 1'b0, p_cs = 1'b1, p_busy = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] b, input logic l, input logic [7:0] exp_rx);
    int n;
    n = 0;
    while (busy_a && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (busy_a) chk("xfer_busy_timeout", 1, 0);
    start_a   = 1'b1;
    tx_byte_a = b;
    last_a    = l;
    @(posedge sys_clk);
    #1;
    start_a   = 1'b0;
    m_rx_prev = m_active ? m_rx_new : m_rx_prev;
    m_active  = 1'b1;
    m_e0      = cyc;
    m_tx      = b;
    m_last    = l;
    m_rx_new  = exp_rx;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge sys_clk);
    while (busy_a && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    if (busy_a) chk("wait_idle_timeout", 1, 0);
  endtask

  initial begin
    int r0, d0, c0, v0, e0b, n;
    start_a = 0; tx_byte_a = 0; last_a = 0;
    start_b = 0; tx_byte_b = 0; last_b = 0;

    fork
      forever begin
        @(posedge sys_clk);
        cyc++;
      end
      forever begin : mon
        int t, e_sclk, e_done, e_busy, e_cs, e_tx, e_rx;
        @(negedge sys_clk);
        if (sclk_a && !p_sclk) begin
          rise_cnt++;
          tx_seen = {tx_seen[6:0], tx_a};
        end
        if (done_a) begin
          done_cnt++;
          t_done = cyc - m_e0;
        end
        if (cs_a && !p_cs) begin
          cs_rise_cnt++;
          t_cs = cyc - m_e0;
        end
        if (!busy_a && p_busy) t_busy = cyc - m_e0;
        p_sclk = sclk_a; p_cs = cs_a; p_busy = busy_a;
        if (chk_en) begin
          t = cyc - m_e0;
          e_sclk = 0; e_done = 0; e_busy = 0; e_cs = 1; e_tx = 0; e_rx = int'(m_rx_prev);
          if (m_active) begin
            if (t < 16*H) begin
              e_busy = 1; e_cs = 0;
              e_sclk = (t / H) % 2;
              e_tx   = int'(m_tx[7 - t/(2*H)]);
            end else begin
              e_rx   = int'(m_rx_new);
              e_done = (t == 16*H) ? 1 : 0;
              if (m_last) begin
                e_busy = (t < 18*H) ? 1 : 0;
                e_cs   = (t >= 17*H) ? 1 : 0;
                e_tx   = (t < 17*H) ? int'(m_tx[0]) : 0;
              end else begin
                e_busy = 0; e_cs = 0; e_tx = int'(m_tx[0]);
              end
            end
          end
          chk("sclk", int'(sclk_a), e_sclk);
          chk("done", int'(done_a), e_done);
          chk("busy", int'(busy_a), e_busy);
          chk("cs_n", int'(cs_a), e_cs);
          chk("spi_tx", int'(tx_a), e_tx);
          chk("rx_byte", int'(rx_byte_a), e_rx);
        end
      end
    join_none

    // Reset values
    #12;
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_rx_byte", int'(rx_byte_a), 0);
    chk("rst_sclk", int'(sclk_a), 0);
    chk("rst_cs_n", int'(cs_a), 1);
    chk("rst_tx", int'(tx_a), 0);
    chk("rst_cs_n_b", int'(cs_b), 1);
    repeat (3) @(negedge sys_clk);
    sys_reset_n = 1'b1;
    chk_en = 1'b1;

    // Idle: no activity for 100 cycles
    r0 = rise_cnt; d0 = done_cnt;
    repeat (100) @(negedge sys_clk);
    chk("idle_sclk_rises", rise_cnt - r0, 0);
    chk("idle_done", done_cnt - d0, 0);
    chk("idle_tx", int'(tx_a), 0);

    // Single byte to the modelled target
    loop_a = 1'b0; ta_pre = 8'h5B;
    d0 = done_cnt; tx_seen = 8'h00;
    xfer(8'hDA, 1'b1, 8'h5B);
    wait_idle();
    chk("t1_tx_bits", int'(tx_seen), 8'hDA);
    chk("t1_done_time", t_done, 64);
    chk("t1_rx_byte", int'(rx_byte_a), 8'h5B);
    chk("t1_cs_rise_time", t_cs, 68);
    chk("t1_busy_fall_time", t_busy, 72);
    chk("t1_done_count", done_cnt - d0, 1);

    // Consecutive bytes in loopback with CS held
    loop_a = 1'b1;
    r0 = rise_cnt; c0 = cs_rise_cnt;
    xfer(8'hDA, 1'b0, 8'hDA);
    wait_idle();
    chk("t2_rx_first", int'(rx_byte_a), 8'hDA);
    chk("t2_cs_between", int'(cs_a), 0);
    xfer(8'h5B, 1'b1, 8'h5B);
    wait_idle();
    chk("t2_rx_second", int'(rx_byte_a), 8'h5B);
    chk("t2_sclk_rises", rise_cnt - r0, 16);
    chk("t2_cs_rises", cs_rise_cnt - c0, 1);

    // start while busy is ignored
    d0 = done_cnt;
    xfer(8'hDA, 1'b1, 8'hDA);
    n = 0;
    while (cyc < m_e0 + 9 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    start_a = 1'b1; tx_byte_a = 8'hFF; last_a = 1'b0;
    @(posedge sys_clk);
    #1;
    start_a = 1'b0;
    wait_idle();
    chk("t3_done_count", done_cnt - d0, 1);
    chk("t3_rx_byte", int'(rx_byte_a), 8'hDA);

    // Reset mid-byte after three rising sclk edges
    xfer(8'hC3, 1'b1, 8'hC3);
    r0 = rise_cnt; n = 0;
    while (rise_cnt < r0 + 3 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t4_three_rises", rise_cnt - r0, 3);
    d0 = done_cnt;
    #2;
    sys_reset_n = 1'b0;
    m_active = 1'b0; m_rx_prev = 8'h00;
    #1;
    chk("t4_cs_n", int'(cs_a), 1);
    chk("t4_sclk", int'(sclk_a), 0);
    chk("t4_busy", int'(busy_a), 0);
    chk("t4_rx_byte", int'(rx_byte_a), 0);
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("t4_no_done", done_cnt - d0, 0);
    xfer(8'h5B, 1'b1, 8'h5B);
    wait_idle();
    chk("t4_rx_after", int'(rx_byte_a), 8'h5B);

    // HALF=2 instance against the target model
    v0 = tb_valid;
    @(negedge sys_clk);
    start_b = 1'b1; tx_byte_b = 8'hA5; last_b = 1'b1;
    @(posedge sys_clk);
    #1;
    start_b = 1'b0;
    e0b = cyc; n = 0;
    @(negedge sys_clk);
    while (!done_b && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("b_done_time", cyc - e0b, 16*HB);
    chk("b_rx_byte", int'(rx_byte_b), 8'h3C);
    n = 0;
    while (busy_b && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    chk("b_busy_fall_time", cyc - e0b, 18*HB);
    chk("b_target_rcv", int'(tb_rcv), 8'hA5);
    chk("b_target_valid", tb_valid - v0, 1);

    repeat (4) @(negedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
